// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the seven-segment display path.
package seg7_pkg;
  localparam int NUM_DIGITS = 4;
  localparam logic [0:6] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] DIGIT_OFF = 4'b1111;
  // Active-low segment patterns, index = hex nibble, bit order abcdefg
  localparam logic [0:6] SEG_LUT [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: combinational hex nibble to active-low segment decoder.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [0:6] seg
);
  assign seg = SEG_LUT[nib];
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 4-digit multiplexed display scan with per-frame value latch.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic        freeze,
  input  logic        blank_lz,
  output logic [0:6]  seg,
  output logic [3:0]  digit,
  output logic        frame_tick
);
  localparam int IW = $clog2(NUM_DIGITS);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [15:0] disp_q, disp_d;
  logic adv, last, blank;
  logic [3:0] nib, digit_d;
  logic [0:6] hex_seg, seg_d;
  hex_to_seg7 u_dec (.nib(nib), .seg(hex_seg));
  always_comb begin
    adv = cnt_q == CNT_W'(REFRESH_DIV - 1);
    last = adv && idx_q == IW'(NUM_DIGITS - 1);
    cnt_d = adv ? '0 : cnt_q + CNT_W'(1);
    idx_d = adv ? idx_q + IW'(1) : idx_q;
    disp_d = (last && !freeze) ? value : disp_q;
    nib = disp_q[{idx_q, 2'b00} +: 4];
    // A digit is a leading zero when it and everything above it is zero
    blank = blank_lz && idx_q != '0 && (disp_q >> {idx_q, 2'b00}) == 16'h0;
    seg_d = blank ? SEG_BLANK : hex_seg;
    digit_d = ~(4'b0001 << idx_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
      disp_q <= '0;
      seg <= SEG_BLANK;
      digit <= DIGIT_OFF;
      frame_tick <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      disp_q <= disp_d;
      seg <= seg_d;
      digit <= digit_d;
      frame_tick <= last;
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: scoreboard bench for the scan driver (REFRESH_DIV 4 and 1).
module tb_seg7_scan_driver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] value = 16'h0;
  logic freeze = 1'b0;
  logic blank_lz = 1'b0;
  logic [0:6] s4, s1;
  logic [3:0] d4, d1;
  logic t4, t1;
  logic [11:0] q4[$], q1[$];
  logic [11:0] e4, e1;
  logic [15:0] ed = 16'h0;
  string phase = "init";
  int n_vec = 0, n_err = 0;
  localparam logic [6:0] TBL [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
  always #5 clk = ~clk;
  seg7_scan_driver #(.REFRESH_DIV(4), .CNT_W(2)) u4 (
    .clk(clk), .rst(rst), .value(value), .freeze(freeze), .blank_lz(blank_lz),
    .seg(s4), .digit(d4), .frame_tick(t4));
  seg7_scan_driver #(.REFRESH_DIV(1), .CNT_W(1)) u1 (
    .clk(clk), .rst(rst), .value(value), .freeze(freeze), .blank_lz(blank_lz),
    .seg(s1), .digit(d1), .frame_tick(t1));
  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got tick/digit/seg=%b/%b/%b, expected %b/%b/%b at %0t",
               tag, got[11], got[10:7], got[6:0], exp[11], exp[10:7], exp[6:0], $time);
    end
  endtask
  function automatic logic [11:0] expv(input logic [15:0] d, input int k, input logic blz, input logic tk);
    logic [15:0] up;
    logic [6:0] s;
    up = d >> (4 * k);
    s = (blz && k > 0 && up == 16'h0) ? 7'b1111111 : TBL[up[3:0]];
    return {tk, 4'hF ^ 4'(1 << k), s};
  endfunction
  always @(posedge clk) begin
    #1;
    if (q4.size() != 0) begin
      e4 = q4.pop_front();
      chk({phase, "/div4"}, {t4, d4, s4}, e4);
    end
    if (q1.size() != 0) begin
      e1 = q1.pop_front();
      chk({phase, "/div1"}, {t1, d1, s1}, e1);
    end
  end
  task automatic do_reset();
    rst = 1'b1;
    q4.push_back({1'b0, 4'b1111, 7'b1111111});
    q1.push_back({1'b0, 4'b1111, 7'b1111111});
    ed = 16'h0;
    @(negedge clk);
    rst = 1'b0;
  endtask
  // One scan frame: va for the first half, vb for the rest; vb is what gets latched
  task automatic frame(input logic [15:0] va, input logic [15:0] vb, input logic frz,
                       input logic blz, input int n);
    for (int j = 0; j < n; j++) begin
      value = (j < 8) ? va : vb;
      freeze = frz;
      blank_lz = blz;
      q4.push_back(expv(ed, j / 4, blz, j == 15));
      @(negedge clk);
    end
    if (n == 16 && !frz) ed = vb;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    phase = "reset";
    do_reset();
    phase = "basic";
    frame(16'h1234, 16'h1234, 1'b0, 1'b0, 16);
    frame(16'h1234, 16'h1234, 1'b0, 1'b0, 16);
    phase = "coherence";
    frame(16'hABCD, 16'hABCD, 1'b0, 1'b0, 16);
    frame(16'hABCD, 16'h0000, 1'b0, 1'b0, 16);
    phase = "freeze";
    frame(16'h00F0, 16'h00F0, 1'b0, 1'b0, 16);
    frame(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16);
    frame(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16);
    frame(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16);
    phase = "blank_lz";
    frame(16'h0005, 16'h0005, 1'b0, 1'b1, 16);
    frame(16'h0000, 16'h0000, 1'b0, 1'b1, 16);
    frame(16'h1234, 16'h1234, 1'b0, 1'b1, 16);
    phase = "mid_reset";
    frame(16'h1234, 16'h1234, 1'b0, 1'b0, 9);
    do_reset();
    frame(16'h1234, 16'h1234, 1'b0, 1'b0, 16);
    phase = "div1";
    value = 16'h0;
    blank_lz = 1'b0;
    do_reset();
    for (int j = 0; j < 8; j++) begin
      q1.push_back({j % 4 == 3, 4'hF ^ 4'(1 << (j % 4)), 7'b0000001});
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    phase = "drain";
    chk("queues_empty", 12'(q4.size() + q1.size()), 12'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
